// File: rtl/count_bcd_display_if.sv
// count_bcd_display_if: value input, BCD result and display drive bundle
// for the count_bcd_display stage.
interface count_bcd_display_if;
   logic [7:0]  value_in;
   logic [11:0] bcd_out;
   logic        bcd_valid;
   logic        busy;
   logic [2:0]  an_n;
   logic [6:0]  seg_n;

   modport master (
      output value_in,
      input  bcd_out, bcd_valid, busy, an_n, seg_n
   );

   modport slave (
      input  value_in,
      output bcd_out, bcd_valid, busy, an_n, seg_n
   );
endinterface

// File: rtl/count_bcd_display.sv
// count_bcd_display: sequential double-dabble BCD converter driving a
// 3-digit active-low 7-seg mux; LEADING_ZERO_BLANK_EN blanks leading zeros.
module count_bcd_display #(
   parameter int REFRESH_DIV = 50000
) (
   input  logic               clk,
   input  logic               reset,
   count_bcd_display_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t      state_q, state_d;
   logic [19:0] shift_q, shift_d;
   logic [19:0] adj;
   logic [3:0]  cnt_q, cnt_d;
   logic [7:0]  last_q, last_d;
   logic [11:0] bcd_q, bcd_d;
   logic        valid_q, valid_d;

   always_comb begin
      adj = shift_q;
      if (shift_q[11:8] >= 4'd5)
         adj[11:8] = shift_q[11:8] + 4'd3;
      if (shift_q[15:12] >= 4'd5)
         adj[15:12] = shift_q[15:12] + 4'd3;
      if (shift_q[19:16] >= 4'd5)
         adj[19:16] = shift_q[19:16] + 4'd3;
   end

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      bcd_d   = bcd_q;
      valid_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.value_in != last_q) begin
               shift_d = {12'h000, bus.value_in};
               last_d  = bus.value_in;
               cnt_d   = 4'd0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            shift_d = adj << 1;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7)
               state_d = DONE;
         end
         DONE: begin
            bcd_d   = shift_q[19:8];
            valid_d = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         shift_q <= 20'h0;
         cnt_q   <= 4'd0;
         last_q  <= 8'h00;
         bcd_q   <= 12'h000;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         bcd_q   <= bcd_d;
         valid_q <= valid_d;
      end
   end

   // Display multiplexer runs free of the converter
   localparam logic [19:0] TC = 20'(REFRESH_DIV - 1);

   logic [19:0] pre_q;
   logic [1:0]  sel_q;
   logic [2:0]  an_q, an_d;
   logic [6:0]  seg_q, seg_d;
   logic [3:0]  nib;
   logic        blank;

   always_comb begin
      an_d  = 3'b111;
      nib   = 4'd0;
      blank = 1'b0;
      unique case (sel_q)
         2'd0: begin
            an_d = 3'b110;
            nib  = bcd_q[3:0];
         end
         2'd1: begin
            an_d = 3'b101;
            nib  = bcd_q[7:4];
`ifdef LEADING_ZERO_BLANK_EN
            blank = (bcd_q[11:4] == 8'h00);
`endif
         end
         2'd2: begin
            an_d = 3'b011;
            nib  = bcd_q[11:8];
`ifdef LEADING_ZERO_BLANK_EN
            blank = (bcd_q[11:8] == 4'h0);
`endif
         end
         default: blank = 1'b1;
      endcase
      unique case (nib)
         4'd0:    seg_d = 7'h40;
         4'd1:    seg_d = 7'h79;
         4'd2:    seg_d = 7'h24;
         4'd3:    seg_d = 7'h30;
         4'd4:    seg_d = 7'h19;
         4'd5:    seg_d = 7'h12;
         4'd6:    seg_d = 7'h02;
         4'd7:    seg_d = 7'h78;
         4'd8:    seg_d = 7'h00;
         4'd9:    seg_d = 7'h10;
         default: seg_d = 7'h7F;
      endcase
      if (blank)
         seg_d = 7'h7F;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pre_q <= 20'h0;
         sel_q <= 2'd0;
         an_q  <= 3'b110;
         seg_q <= 7'h40;
      end else begin
         an_q  <= an_d;
         seg_q <= seg_d;
         if (pre_q >= TC) begin
            pre_q <= 20'h0;
            sel_q <= (sel_q == 2'd2) ? 2'd0 : sel_q + 2'd1;
         end else begin
            pre_q <= pre_q + 20'h1;
         end
      end
   end

   assign bus.bcd_out   = bcd_q;
   assign bus.bcd_valid = valid_q;
   assign bus.busy      = (state_q != IDLE);
   assign bus.an_n      = an_q;
   assign bus.seg_n     = seg_q;
endmodule

// File: tb/tb_count_bcd_display.sv
// tb_count_bcd_display: scoreboard bench for the BCD converter and
// display multiplexer (REFRESH_DIV=4).
module tb_count_bcd_display;
   logic clk;
   logic reset;
   int   total;
   int   bad;
   logic [11:0] q[$];

   count_bcd_display_if bus ();

   count_bcd_display #(.REFRESH_DIV(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200us;
      $display("FAIL watchdog: run did not finish");
      $fatal(1);
   end

   // Scoreboard: every bcd_valid pulse must match the oldest expectation
   always @(negedge clk) begin
      if (bus.bcd_valid === 1'b1) begin
         total++;
         if (q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_valid: bcd_out=%h, none expected",
                     bus.bcd_out);
         end else begin
            logic [11:0] e;
            e = q.pop_front();
            if (bus.bcd_out !== e) begin
               bad++;
               $display("FAIL sb_bcd: got %h want %h", bus.bcd_out, e);
            end
         end
      end
   end

   task automatic test_reset();
      bit seen;
      reset = 1'b0;
      bus.value_in = 8'd0;
      #1;
      total++;
      if (bus.bcd_out !== 12'h000 || bus.bcd_valid !== 1'b0 ||
          bus.busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_conv: bcd=%h v=%b b=%b want 000 0 0",
                  bus.bcd_out, bus.bcd_valid, bus.busy);
      end
      total++;
      if (bus.an_n !== 3'b110 || bus.seg_n !== 7'h40) begin
         bad++;
         $display("FAIL reset_disp: an=%b seg=%h want 110 40",
                  bus.an_n, bus.seg_n);
      end
      repeat (2) @(negedge clk);
      reset = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.busy !== 1'b0 || bus.bcd_valid !== 1'b0) seen = 1'b1;
      end
      total++;
      if (seen || bus.bcd_out !== 12'h000) begin
         bad++;
         $display("FAIL idle_zero: activity=%b bcd=%h want 0 000",
                  seen, bus.bcd_out);
      end
   endtask

   task automatic test_single();
      bus.value_in = 8'd123;
      q.push_back(12'h123);
      for (int k = 1; k <= 11; k++) begin
         @(negedge clk);
         if (k == 1) begin
            total++;
            if (bus.busy !== 1'b1) begin
               bad++;
               $display("FAIL busy_start: got %b want 1", bus.busy);
            end
         end
         if (k == 9) begin
            total++;
            if (bus.bcd_out !== 12'h000 || bus.bcd_valid !== 1'b0) begin
               bad++;
               $display("FAIL early_update: bcd=%h v=%b want 000 0",
                        bus.bcd_out, bus.bcd_valid);
            end
         end
         if (k == 10) begin
            total++;
            if (bus.bcd_out !== 12'h123 || bus.bcd_valid !== 1'b1) begin
               bad++;
               $display("FAIL latency10: bcd=%h v=%b want 123 1",
                        bus.bcd_out, bus.bcd_valid);
            end
         end
         if (k == 11) begin
            total++;
            if (bus.bcd_valid !== 1'b0 || bus.busy !== 1'b0) begin
               bad++;
               $display("FAIL pulse_len: v=%b b=%b want 0 0",
                        bus.bcd_valid, bus.busy);
            end
         end
      end
   endtask

   task automatic test_sequence();
      logic [7:0]  v [3];
      logic [11:0] e [3];
      v = '{8'd255, 8'd199, 8'd9};
      e = '{12'h255, 12'h199, 12'h009};
      for (int i = 0; i < 3; i++) begin
         bus.value_in = v[i];
         q.push_back(e[i]);
         repeat (20) @(negedge clk);
         total++;
         if (bus.bcd_out !== e[i]) begin
            bad++;
            $display("FAIL seq_hold: got %h want %h", bus.bcd_out, e[i]);
         end
      end
      for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL seq_drain: %0d pending want 0", q.size());
      end
   endtask

   task automatic test_back_to_back();
      int pulses;
      pulses = 0;
      bus.value_in = 8'd50;
      q.push_back(12'h050);
      q.push_back(12'h051);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (i == 2) bus.value_in = 8'd51;
         if (bus.bcd_valid === 1'b1) pulses++;
      end
      total++;
      if (pulses != 2) begin
         bad++;
         $display("FAIL b2b_pulses: got %0d want 2", pulses);
      end
      total++;
      if (q.size() != 0 || bus.bcd_out !== 12'h051) begin
         bad++;
         $display("FAIL b2b_final: bcd=%h pend=%0d want 051 0",
                  bus.bcd_out, q.size());
      end
   endtask

   task automatic test_display();
      logic [2:0] ea [3];
      logic [6:0] es [3];
      logic [2:0] prev;
      bit found;
      ea = '{3'b110, 3'b101, 3'b011};
      es = '{7'h78, 7'h19, 7'h79};
      bus.value_in = 8'd147;
      q.push_back(12'h147);
      repeat (14) @(negedge clk);
      found = 1'b0;
      prev = bus.an_n;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (prev !== 3'b110 && bus.an_n === 3'b110) found = 1'b1;
         prev = bus.an_n;
      end
      total++;
      if (!found) begin
         bad++;
         $display("FAIL mux_sync: an=%b never entered 110", bus.an_n);
      end
      for (int i = 0; i < 12; i++) begin
         if (i != 0) @(negedge clk);
         total++;
         if (bus.an_n !== ea[i/4] || bus.seg_n !== es[i/4]) begin
            bad++;
            $display("FAIL mux_%0d: an=%b seg=%h want %b %h",
                     i, bus.an_n, bus.seg_n, ea[i/4], es[i/4]);
         end
      end
   endtask

   task automatic test_blank();
      logic [6:0] lz;
`ifdef LEADING_ZERO_BLANK_EN
      lz = 7'h7F;
`else
      lz = 7'h40;
`endif
      bus.value_in = 8'd7;
      q.push_back(12'h007);
      repeat (14) @(negedge clk);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         total++;
         if (bus.an_n === 3'b110) begin
            if (bus.seg_n !== 7'h78) begin
               bad++;
               $display("FAIL blank_units: seg=%h want 78", bus.seg_n);
            end
         end else if (bus.an_n === 3'b101 || bus.an_n === 3'b011) begin
            if (bus.seg_n !== lz) begin
               bad++;
               $display("FAIL blank_lead: an=%b seg=%h want %h",
                        bus.an_n, bus.seg_n, lz);
            end
         end else begin
            bad++;
            $display("FAIL blank_an: an=%b not one-hot low", bus.an_n);
         end
      end
   endtask

   task automatic test_reset_mid();
      bus.value_in = 8'd200;
      repeat (4) @(negedge clk);
      total++;
      if (bus.busy !== 1'b1) begin
         bad++;
         $display("FAIL mid_busy: got %b want 1", bus.busy);
      end
      reset = 1'b0;
      #1;
      total++;
      if (bus.bcd_out !== 12'h000 || bus.bcd_valid !== 1'b0 ||
          bus.busy !== 1'b0 || bus.an_n !== 3'b110 ||
          bus.seg_n !== 7'h40) begin
         bad++;
         $display("FAIL mid_reset: bcd=%h v=%b b=%b an=%b seg=%h",
                  bus.bcd_out, bus.bcd_valid, bus.busy,
                  bus.an_n, bus.seg_n);
      end
      repeat (2) @(negedge clk);
      bus.value_in = 8'd88;
      q.push_back(12'h088);
      reset = 1'b1;
      for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
      total++;
      if (q.size() != 0 || bus.bcd_out !== 12'h088) begin
         bad++;
         $display("FAIL post_reset: bcd=%h pend=%0d want 088 0",
                  bus.bcd_out, q.size());
      end
   endtask

   initial begin
      total = 0;
      bad = 0;
      reset = 1'b0;
      bus.value_in = 8'd0;
      @(negedge clk);
      test_reset();
      test_single();
      test_sequence();
      test_back_to_back();
      test_display();
      test_blank();
      test_reset_mid();
      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
